// File: rtl/prt_scaler_vsc_if.sv
// Control/handshake bundle for the vertical scaler line sequencer.
//   master : drives run enable, frame config, sync inputs and the fetch ack;
//            observes line-buffer commands, line outputs and status.
//   slave  : the sequencer itself (prt_scaler_vsc).
// Signals:
//   ctl_run        run enable; low forces idle and clears all outputs
//   cfg_src_lines  source active lines per frame
//   cfg_dst_lines  output active lines per frame
//   cfg_step       src/dst step, Q1.P_FRAC
//   vs, hs         vsync / hsync, rising edge marks frame / line start
//   src_ack        upstream reader accepted the pending source-line request
//   src_req        source-line fetch request, level, held until acked
//   lb_adv         one-cycle pulse: shift next source line into line buffer
//   line_en        current output line valid
//   last           bottom source line absent, datapath repeats top line
//   phase          bottom-line blend weight for current output line
//   sta_ufl        sticky: advance issued while a request was still pending
//   sta_busy       sequencer is mid-frame
interface prt_scaler_vsc_if #(
  parameter int P_LINE_W = 11,
  parameter int P_FRAC   = 12,
  parameter int P_PHASE  = 8
);
  logic                ctl_run;
  logic [P_LINE_W-1:0] cfg_src_lines;
  logic [P_LINE_W-1:0] cfg_dst_lines;
  logic [P_FRAC:0]     cfg_step;
  logic                vs;
  logic                hs;
  logic                src_ack;
  logic                src_req;
  logic                lb_adv;
  logic                line_en;
  logic                last;
  logic [P_PHASE-1:0]  phase;
  logic                sta_ufl;
  logic                sta_busy;

  modport master (
    output ctl_run, cfg_src_lines, cfg_dst_lines, cfg_step, vs, hs, src_ack,
    input  src_req, lb_adv, line_en, last, phase, sta_ufl, sta_busy
  );

  modport slave (
    input  ctl_run, cfg_src_lines, cfg_dst_lines, cfg_step, vs, hs, src_ack,
    output src_req, lb_adv, line_en, last, phase, sta_ufl, sta_busy
  );
endinterface

// File: rtl/prt_scaler_vsc.sv
// Vertical scaler line sequencer (upscale 1x..2x).
// Primes the two-line buffer at frame start, then on every hsync computes the
// active source-line pair and blend phase, pulses line-buffer advances and
// handshakes source-line fetches with the upstream reader.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    prt_scaler_vsc_if.slave (config, syncs, fetch handshake, outputs)
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for first vsync after reset / run enable
// PRIME0 | next hsync loads first source line into the line buffer
// PRIME1 | next hsync loads second source line
// RUN    | one output line per hsync; advance buffer when index moves
// DONE   | frame complete (or degenerate config); hsync ignored
module prt_scaler_vsc #(
  parameter int P_LINE_W = 11,
  parameter int P_FRAC   = 12,
  parameter int P_PHASE  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  prt_scaler_vsc_if.slave  bus
);

  localparam int ACC_W = P_LINE_W + P_FRAC;
  localparam logic [P_FRAC:0] STEP_ONE  = {1'b1, {P_FRAC{1'b0}}};
  localparam logic [P_FRAC:0] STEP_HALF = {2'b01, {(P_FRAC-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME0, S_PRIME1, S_RUN, S_DONE
  } state_t;

  state_t              state;
  logic                vs_d, hs_d;
  logic [P_LINE_W-1:0] src_lines, dst_lines;
  logic [P_FRAC:0]     step;
  logic [ACC_W-1:0]    acc;
  logic [P_LINE_W-1:0] olc, loaded;

  logic                src_req_q, lb_adv_q, line_en_q, last_q, ufl_q, busy_q;
  logic [P_PHASE-1:0]  phase_q;

  logic                vs_re, hs_re, cfg_bad, is_last, need_adv, adv_now;
  logic [P_FRAC:0]     step_clamped;
  logic [ACC_W-1:0]    acc_next;
  logic [P_LINE_W-1:0] line_idx, next_idx;

  assign vs_re = bus.vs & ~vs_d;
  assign hs_re = bus.hs & ~hs_d;

  always_comb begin
    step_clamped = bus.cfg_step;
    if (bus.cfg_step == '0 || bus.cfg_step > STEP_ONE) step_clamped = STEP_ONE;
    else if (bus.cfg_step < STEP_HALF)                  step_clamped = STEP_HALF;
  end

  assign cfg_bad  = (bus.cfg_dst_lines == '0) || (bus.cfg_src_lines < P_LINE_W'(2));

  assign line_idx = acc[ACC_W-1:P_FRAC];
  assign acc_next = acc + ACC_W'(step);
  assign next_idx = acc_next[ACC_W-1:P_FRAC];
  // Bottom line of the pair (index+1) falls past the last source line.
  assign is_last  = ({1'b0, line_idx} + (P_LINE_W+1)'(1)) >= {1'b0, src_lines};
  // Advance only when the integer index moves and unfetched lines remain.
  assign need_adv = (next_idx > line_idx) && (loaded < src_lines);

  always_comb begin
    adv_now = 1'b0;
    if (hs_re && !vs_re) begin
      case (state)
        S_PRIME0, S_PRIME1: adv_now = 1'b1;
        S_RUN:              adv_now = (olc != dst_lines) && need_adv;
        default:            adv_now = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vs_d      <= 1'b0;
      hs_d      <= 1'b0;
      src_lines <= '0;
      dst_lines <= '0;
      step      <= '0;
      acc       <= '0;
      olc       <= '0;
      loaded    <= '0;
      src_req_q <= 1'b0;
      lb_adv_q  <= 1'b0;
      line_en_q <= 1'b0;
      last_q    <= 1'b0;
      phase_q   <= '0;
      ufl_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      vs_d <= bus.vs;
      hs_d <= bus.hs;
      if (!bus.ctl_run) begin
        state     <= S_IDLE;
        acc       <= '0;
        olc       <= '0;
        loaded    <= '0;
        src_req_q <= 1'b0;
        lb_adv_q  <= 1'b0;
        line_en_q <= 1'b0;
        last_q    <= 1'b0;
        phase_q   <= '0;
        ufl_q     <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        lb_adv_q <= adv_now;
        // A new request takes priority over an ack arriving the same cycle.
        if (adv_now)                  src_req_q <= 1'b1;
        else if (src_req_q && bus.src_ack) src_req_q <= 1'b0;
        if (adv_now && src_req_q)     ufl_q <= 1'b1;

        if (vs_re) begin
          src_lines <= bus.cfg_src_lines;
          dst_lines <= bus.cfg_dst_lines;
          step      <= step_clamped;
          acc       <= '0;
          olc       <= '0;
          loaded    <= '0;
          ufl_q     <= 1'b0;
          line_en_q <= 1'b0;
          last_q    <= 1'b0;
          phase_q   <= '0;
          if (cfg_bad) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
          end else begin
            state  <= S_PRIME0;
            busy_q <= 1'b1;
          end
        end else if (hs_re) begin
          case (state)
            S_PRIME0: begin
              loaded <= P_LINE_W'(1);
              state  <= S_PRIME1;
            end
            S_PRIME1: begin
              loaded <= P_LINE_W'(2);
              state  <= S_RUN;
            end
            S_RUN: begin
              if (olc == dst_lines) begin
                line_en_q <= 1'b0;
                last_q    <= 1'b0;
                phase_q   <= '0;
                busy_q    <= 1'b0;
                state     <= S_DONE;
              end else begin
                line_en_q <= 1'b1;
                last_q    <= is_last;
                phase_q   <= is_last ? '0 : acc[P_FRAC-1 -: P_PHASE];
                if (need_adv) loaded <= loaded + P_LINE_W'(1);
                acc <= acc_next;
                olc <= olc + P_LINE_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.src_req  = src_req_q;
  assign bus.lb_adv   = lb_adv_q;
  assign bus.line_en  = line_en_q;
  assign bus.last     = last_q;
  assign bus.phase    = phase_q;
  assign bus.sta_ufl  = ufl_q;
  assign bus.sta_busy = busy_q;

endmodule

// File: tb/tb_prt_scaler_vsc.sv
module tb_prt_scaler_vsc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prt_scaler_vsc_if #(.P_LINE_W(11), .P_FRAC(12), .P_PHASE(8)) bus ();

  prt_scaler_vsc #(.P_LINE_W(11), .P_FRAC(12), .P_PHASE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       line_en;
    logic [7:0] phase;
    logic       last;
    logic       adv;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic ack_en  = 1'b1;

  function automatic exp_t mk(logic le, logic [7:0] ph, logic la, logic adv, logic busy);
    exp_t e;
    e.line_en = le; e.phase = ph; e.last = la; e.adv = adv; e.busy = busy;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: the DUT presents a new line/frame response the cycle after each
  // sync rising edge; compare that response against the scoreboard head.
  initial begin
    logic hs_prev, vs_prev, ev;
    exp_t got, e;
    int   n_ev;
    hs_prev = 1'b0; vs_prev = 1'b0; n_ev = 0;
    forever begin
      @(posedge clk);
      ev = rst_n && ((bus.hs && !hs_prev) || (bus.vs && !vs_prev));
      hs_prev = bus.hs;
      vs_prev = bus.vs;
      @(negedge clk);
      got = mk(bus.line_en, bus.phase, bus.last, bus.lb_adv, bus.sta_busy);
      if (ev) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL evt%0d: response with empty scoreboard le=%0b ph=%0d last=%0b adv=%0b busy=%0b",
                   n_ev, got.line_en, got.phase, got.last, got.adv, got.busy);
        end else begin
          e = exp_q.pop_front();
          if (got === e) n_pass++;
          else $display("FAIL evt%0d: got le=%0b ph=%0d last=%0b adv=%0b busy=%0b expected le=%0b ph=%0d last=%0b adv=%0b busy=%0b",
                        n_ev, got.line_en, got.phase, got.last, got.adv, got.busy,
                        e.line_en, e.phase, e.last, e.adv, e.busy);
        end
        n_ev++;
      end else if (bus.lb_adv) begin
        n_total++;
        $display("FAIL stray_adv: lb_adv=1 expected 0 outside sync response at %0t", $time);
      end
    end
  end

  // Upstream reader: acks a pending request after a short delay and checks
  // the request holds until the ack and drops on the following cycle.
  initial begin
    bus.src_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && bus.src_req) begin
        repeat (2) @(negedge clk);
        chk("req_hold", {31'b0, bus.src_req}, 32'd1);
        bus.src_ack = 1'b1;
        @(negedge clk);
        bus.src_ack = 1'b0;
        if (!bus.lb_adv) chk("req_clr", {31'b0, bus.src_req}, 32'd0);
      end
    end
  end

  task automatic pulse_hs(input exp_t e);
    exp_q.push_back(e);
    @(negedge clk); bus.hs = 1'b1;
    repeat (2) @(negedge clk); bus.hs = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_vs(input exp_t e);
    exp_q.push_back(e);
    @(negedge clk); bus.vs = 1'b1;
    repeat (2) @(negedge clk); bus.vs = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // One frame: vsync, two priming lines, up to 'stop' output lines, then the
  // terminating hsync plus one ignored hsync in DONE if the frame completes.
  task automatic frame(input logic [12:0] step, input int src, input int dst,
                       input logic [15:0] adv_m, input logic [15:0] last_m,
                       input logic [127:0] ph, input int stop);
    logic ok;
    ok = (dst != 0) && (src >= 2);
    bus.cfg_step      = step;
    bus.cfg_src_lines = 11'(src);
    bus.cfg_dst_lines = 11'(dst);
    pulse_vs(mk(1'b0, 8'd0, 1'b0, 1'b0, ok));
    if (!ok) begin
      pulse_hs(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
      pulse_hs(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
      return;
    end
    pulse_hs(mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b1));
    pulse_hs(mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b1));
    for (int k = 0; k < dst && k < stop; k++)
      pulse_hs(mk(1'b1, ph[8*k +: 8], last_m[k], adv_m[k], 1'b1));
    if (stop >= dst) begin
      pulse_hs(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
      pulse_hs(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  localparam logic [15:0]  ADV_1X  = 16'b0000_0000_0000_0011;
  localparam logic [15:0]  LAST_1X = 16'b0000_0000_0000_1000;
  localparam logic [127:0] PH_1X   = 128'h0;
  localparam logic [15:0]  ADV_2X  = 16'b0000_0000_0000_1010;
  localparam logic [15:0]  LAST_2X = 16'b0000_0000_1100_0000;
  localparam logic [127:0] PH_2X   = 128'h0000_8000_8000_8000;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    bus.ctl_run       = 1'b1;
    bus.vs            = 1'b0;
    bus.hs            = 1'b0;
    bus.cfg_step      = '0;
    bus.cfg_src_lines = '0;
    bus.cfg_dst_lines = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {20'b0, bus.src_req, bus.lb_adv, bus.line_en, bus.last,
        bus.phase, bus.sta_ufl, bus.sta_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1:1 and 2x
    frame(13'd4096, 4, 4, ADV_1X, LAST_1X, PH_1X, 99);
    chk("ufl_1x", {31'b0, bus.sta_ufl}, 32'd0);
    frame(13'd2048, 4, 8, ADV_2X, LAST_2X, PH_2X, 99);

    // Clamps and degenerate config
    frame(13'd0,    4, 4, ADV_1X, LAST_1X, PH_1X, 99);
    frame(13'd1000, 4, 8, ADV_2X, LAST_2X, PH_2X, 99);
    frame(13'd2048, 4, 0, 16'b0, 16'b0, 128'h0, 99);
    chk("busy_dst0", {31'b0, bus.sta_busy}, 32'd0);

    // Mid-frame vsync after output line 2, then a full identical frame
    frame(13'd2048, 4, 8, ADV_2X, LAST_2X, PH_2X, 3);
    frame(13'd2048, 4, 8, ADV_2X, LAST_2X, PH_2X, 99);

    // Underflow: no ack across the advancing PRIME1 hsync
    ack_en = 1'b0;
    frame(13'd2048, 4, 8, ADV_2X, LAST_2X, PH_2X, 0);
    chk("ufl_set", {30'b0, bus.sta_ufl, bus.src_req}, 32'd3);
    ack_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("ufl_sticky", {30'b0, bus.sta_ufl, bus.src_req}, 32'd2);
    frame(13'd2048, 4, 8, ADV_2X, LAST_2X, PH_2X, 99);
    chk("ufl_cleared", {31'b0, bus.sta_ufl}, 32'd0);

    // Async reset mid-RUN, between clock edges
    frame(13'd4096, 4, 4, ADV_1X, LAST_1X, PH_1X, 3);
    chk("line_en_pre_rst", {31'b0, bus.line_en}, 32'd1);
    ack_en = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {20'b0, bus.src_req, bus.lb_adv, bus.line_en, bus.last,
        bus.phase, bus.sta_ufl, bus.sta_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    frame(13'd4096, 4, 4, ADV_1X, LAST_1X, PH_1X, 99);

    // Run low mid-frame: idle next cycle, no response until vsync with run
    frame(13'd2048, 4, 8, ADV_2X, LAST_2X, PH_2X, 2);
    chk("line_en_pre_run", {31'b0, bus.line_en}, 32'd1);
    @(negedge clk); bus.ctl_run = 1'b0;
    @(negedge clk);
    chk("run_low", {29'b0, bus.line_en, bus.sta_busy, bus.src_req}, 32'd0);
    pulse_hs(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    bus.ctl_run = 1'b1;
    pulse_hs(mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    frame(13'd2048, 4, 8, ADV_2X, LAST_2X, PH_2X, 99);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prt_scaler_vsc.md
Name: prt_scaler_vsc

Overview:
Vertical scaler line sequencer. It schedules, line by line, the vertical bilinear line-buffer datapath in the scaler. For each frame it primes the two-line buffer, then on every output line computes which source-line pair is active and the blend phase. It pulses line-advance commands to the line buffer and handshakes source-line fetches with the upstream reader. Upscaling only: ratio 1x..2x.

Parameters:
P_LINE_W, 11, width of line counters (max 2047 lines)
P_FRAC, 12, fractional bits of step/accumulator (Q1.P_FRAC step)
P_PHASE, 8, blend phase output width (top bits of accumulator fraction)

Ports:
CLK_IN  in  1  clock
RSTN_IN  in  1  asynchronous active-low reset
CTL_RUN_IN  in  1  run enable; low forces IDLE and clears all outputs
CFG_SRC_LINES_IN  in  P_LINE_W  source active lines per frame
CFG_DST_LINES_IN  in  P_LINE_W  output active lines per frame
CFG_STEP_IN  in  P_FRAC+1  src/dst step, Q1.P_FRAC (4096 = 1.0 at default)
VS_IN  in  1  vsync (rising edge = frame start)
HS_IN  in  1  hsync (rising edge = line start)
SRC_ACK_IN  in  1  upstream reader accepted source-line request
SRC_REQ_OUT  out  1  source-line fetch request, level, held until ack
LB_ADV_OUT  out  1  one-cycle pulse: shift next source line into line buffer
LINE_EN_OUT  out  1  current output line valid (line-buffer output write enable)
LAST_OUT  out  1  bottom source line absent; datapath repeats top line
PHASE_OUT  out  P_PHASE  bottom-line weight for current output line
STA_UFL_OUT  out  1  sticky: advance needed while request still pending
STA_BUSY_OUT  out  1  state not IDLE/DONE

Behaviour:
- Reset (RSTN_IN low, async) and CTL_RUN_IN low: all outputs 0, state IDLE, counters/accumulator 0.
- VS_IN, HS_IN edge-detected internally (1 register); all actions occur on the cycle after the detected edge; all outputs registered.
- Config latched on every vs_re. Step 0 or > 1.0 clamped to 1.0; step < 0.5 clamped to 0.5. CFG_DST_LINES_IN = 0 or CFG_SRC_LINES_IN < 2: go to DONE immediately.
- vs_re in any state (with run): acc=0, out-line count olc=0, loaded=0, STA_UFL cleared, LINE_EN=0, state PRIME0. Mid-frame vs_re aborts the frame with no further pulses.
- States:
  IDLE: wait vs_re.
  PRIME0: hs_re -> LB_ADV pulse, SRC_REQ set, loaded=1, PRIME1.
  PRIME1: hs_re -> LB_ADV pulse, SRC_REQ set, loaded=2, RUN.
  RUN: per hs_re emit output line olc:
    LINE_EN=1; i=acc>>P_FRAC; PHASE=acc[P_FRAC-1 -: P_PHASE].
    LAST=(i+1 >= src_lines); when LAST, PHASE forced 0.
    adv=(int(acc+step) > i) && (loaded < src_lines); adv -> LB_ADV pulse, loaded+1, SRC_REQ set.
    acc+=step; olc+=1. hs_re with olc == dst_lines -> LINE_EN=0, DONE.
  DONE: ignore hs; wait vs_re.
- PHASE/LAST/LINE_EN held stable from cycle after hs_re until next hs_re.
- SRC_REQ: set with each LB_ADV; cleared the cycle after SRC_ACK_IN sampled high while set. Set and ack in the same cycle: set wins.
- adv while SRC_REQ still high: STA_UFL set (sticky until vs_re); LB_ADV still issued; REQ stays high.
- Accumulator width P_LINE_W+P_FRAC, no wrap within legal config.

Test Plan:
- 1:1: src=4, dst=4, step=4096 -> LINE_EN for 4 lines; PHASE 0,0,0,0; LB_ADV at PRIME0, PRIME1, out lines 0,1 only; LAST only on line 3; then DONE.
- 2x: src=4, dst=8, step=2048 -> PHASE 0,128,0,128,0,128,0,0; LAST on lines 6,7; LB_ADV in RUN on lines 1,3 only (line 5 suppressed, loaded=4).
- Handshake: ack 3 cycles after each REQ -> REQ high exactly until cycle after ack; hold ack low across an advancing hs_re -> STA_UFL=1, cleared on next vs_re.
- Mid-frame vs_re after output line 2 of 8 -> LINE_EN drops cycle after edge, state PRIME0, acc/olc reset, next frame sequence identical to first.
- Clamp/degenerate: step=0 behaves as 4096; step=1000 behaves as 2048; dst=0 -> no LB_ADV, LINE_EN never set, STA_BUSY=0.
- RSTN_IN low mid-RUN (async, between clock edges) -> all outputs 0 immediately; CTL_RUN_IN low -> IDLE next cycle, no pulses until next vs_re after run returns.
